// File: rtl/inst_encoder_pkg.sv
// ---------------------------------------------------------------------------
// inst_encoder_pkg
//   Definitions shared by the instruction encoder and the processor's
//   fetch-stage decoder: instruction word fields, opcode nibbles, the
//   state-number op constants {opcode, subop}, the encoder FSM state type
//   and a helper that builds a Pre word.
// ---------------------------------------------------------------------------
package inst_encoder_pkg;

    // Instruction word layout: [15:12] opcode, [11:0] immediate.
    localparam int WORD_W   = 16;
    localparam int OPCODE_W = 4;
    localparam int IMMED_W  = 12;
    // A Pre word carries the upper immediate nibble in its low 4 bits.
    localparam int PRE_W    = 4;

    // Opcode nibbles (upper half of a state-number op).
    localparam logic [3:0] OPC_ALU   = 4'h0;
    localparam logic [3:0] OPC_PUSH  = 4'h1;
    localparam logic [3:0] OPC_CALL  = 4'h4;
    localparam logic [3:0] OPC_JUMP  = 4'h5;
    localparam logic [3:0] OPC_JUMPF = 4'h6;
    localparam logic [3:0] OPC_JUMPT = 4'h7;
    localparam logic [3:0] OPC_GET   = 4'h8;
    localparam logic [3:0] OPC_PUT   = 4'h9;
    localparam logic [3:0] OPC_POP   = 4'hA;
    localparam logic [3:0] OPC_PRE   = 4'hB;

    // State-number op constants {opcode, subop}.
    localparam logic [7:0] OP_ADD   = 8'h00;
    localparam logic [7:0] OP_SYS   = 8'h0B;  // last legal opcode-0 subop
    localparam logic [7:0] OP_PUSH  = 8'h10;
    localparam logic [7:0] OP_CALL  = 8'h40;
    localparam logic [7:0] OP_JUMP  = 8'h50;
    localparam logic [7:0] OP_JUMPF = 8'h60;
    localparam logic [7:0] OP_JUMPT = 8'h70;
    localparam logic [7:0] OP_GET   = 8'h80;
    localparam logic [7:0] OP_PUT   = 8'h90;
    localparam logic [7:0] OP_POP   = 8'hA0;
    localparam logic [7:0] OP_PRE   = 8'hB0;
    localparam logic [7:0] OP_NOP   = 8'hF0;

    // Register-field value the processor uses for "no register operand".
    localparam logic [3:0] NOREG = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EMIT_PRE  = 2'd1,
        ST_EMIT_MAIN = 2'd2
    } enc_state_t;

    // Pre word supplying immed[15:12] to the following instruction.
    function automatic logic [WORD_W-1:0] make_pre(input logic [15:0] immed);
        return {OPC_PRE, 8'h00, immed[15:12]};
    endfunction

endpackage

// File: rtl/inst_encoder_fit_check.sv
// ---------------------------------------------------------------------------
// enc_fit_check
//   Combinational classifier: decides whether a symbolic instruction is
//   legal, whether its immediate needs a Pre word, and builds both words.
//   Define ENC_ALWAYS_PRE_EN to make Call/Jump/JumpF/JumpT always emit a Pre
//   (position-independent, fixed 2-word size); Push is unaffected.
//
//   Ports:
//     op        in  8   state-number op {opcode, subop}
//     immed     in  16  full immediate / branch target
//     addr      in  16  address the first emitted word will occupy
//     legal     out 1   request can be encoded
//     need_pre  out 1   a Pre word must precede main_word
//     main_word out 16  the instruction word itself
//     pre_word  out 16  Pre word carrying immed[15:12]
// ---------------------------------------------------------------------------
module enc_fit_check
    import inst_encoder_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [15:0] immed,
    input  logic [15:0] addr,
    output logic        legal,
    output logic        need_pre,
    output logic [15:0] main_word,
    output logic [15:0] pre_word
);

    logic [3:0] opcode;
    logic [3:0] subop;

    assign opcode   = op[7:4];
    assign subop    = op[3:0];
    assign pre_word = make_pre(immed);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        legal     = 1'b0;
        need_pre  = 1'b0;
        main_word = {opcode, immed[11:0]};
        case (opcode)
            OPC_ALU: begin
                legal     = (subop <= OP_SYS[3:0]);
                main_word = {OPC_ALU, 8'h00, subop};
            end
            OPC_PUSH: begin
                // The decoder sign-extends bit 11, so bits 15:11 must agree.
                legal    = 1'b1;
                need_pre = !((&immed[15:11]) || !(|immed[15:11]));
            end
            OPC_CALL, OPC_JUMP, OPC_JUMPF, OPC_JUMPT: begin
                legal = 1'b1;
`ifdef ENC_ALWAYS_PRE_EN
                need_pre = 1'b1;
`else
                // Without a Pre the decoder takes bits 14:12 from the jump
                // word's own address and forces bit 15 to zero.
                need_pre = immed[15] || (immed[14:12] != addr[14:12]);
`endif
            end
            OPC_GET, OPC_PUT, OPC_POP: begin
                legal = (immed[15:12] == 4'h0);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// ---------------------------------------------------------------------------
// inst_encoder
//   Turns a symbolic instruction (state-number op + 16-bit immediate) into
//   the 16-bit words instruction memory holds, inserting a Pre word when the
//   decoder could not rebuild the immediate alone, and tracks the memory
//   address of every emitted word.
//   Optional macro: ENC_ALWAYS_PRE_EN (see enc_fit_check).
//
//   Ports:
//     clk        in  1   clock, all state on posedge
//     reset      in  1   asynchronous active-high reset
//     in_valid   in  1   request present
//     in_ready   out 1   request accepted this cycle
//     in_op      in  8   op {opcode, subop}
//     in_immed   in  16  immediate / target
//     load_addr  in  1   load address counter (honoured only when idle)
//     base_addr  in  16  value for load_addr
//     out_valid  out 1   out_word/out_addr valid
//     out_ready  in  1   consumer takes the word
//     out_word   out 16  encoded instruction word
//     out_addr   out 16  memory address of out_word
//     err        out 1   pulse: illegal request accepted and dropped
// ---------------------------------------------------------------------------
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_op,
    input  logic [15:0] in_immed,
    input  logic        load_addr,
    input  logic [15:0] base_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_word,
    output logic [15:0] out_addr,
    output logic        err
);

    enc_state_t  state;
    enc_state_t  state_next;
    logic [15:0] addr;
    logic [15:0] main_q;
    logic        accept;
    logic        out_fire;

    logic        fit_legal;
    logic        fit_need_pre;
    logic [15:0] fit_main;
    logic [15:0] fit_pre;

    enc_fit_check u_fit (
        .op        (in_op),
        .immed     (in_immed),
        .addr      (addr),
        .legal     (fit_legal),
        .need_pre  (fit_need_pre),
        .main_word (fit_main),
        .pre_word  (fit_pre)
    );

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign out_addr = addr;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept && fit_legal) begin
                    state_next = fit_need_pre ? ST_EMIT_PRE : ST_EMIT_MAIN;
                end
            end
            ST_EMIT_PRE: begin
                if (out_ready) state_next = ST_EMIT_MAIN;
            end
            ST_EMIT_MAIN: begin
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        in_ready  = (state == ST_IDLE) && !load_addr;
        out_valid = (state != ST_IDLE);
    end

    // Address counter, word registers and error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr     <= RESET_ADDR;
            out_word <= 16'h0000;
            main_q   <= 16'h0000;
            err      <= 1'b0;
        end else begin
            err <= accept && !fit_legal;

            if ((state == ST_IDLE) && load_addr) begin
                addr <= base_addr;
            end else if (out_fire) begin
                addr <= addr + 16'd1;
            end

            if (accept && fit_legal) begin
                out_word <= fit_need_pre ? fit_pre : fit_main;
                main_q   <= fit_main;
            end else if ((state == ST_EMIT_PRE) && out_ready) begin
                out_word <= main_q;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// ---------------------------------------------------------------------------
// tb_inst_encoder
//   Self-checking bench for inst_encoder: table of requests with expected
//   words, a scoreboard queue of {word, addr} popped on each output
//   handshake, and hand-written sequences for back-pressure and reset.
// ---------------------------------------------------------------------------
module tb_inst_encoder;

`ifdef ENC_ALWAYS_PRE_EN
    localparam bit ALWAYS_PRE = 1'b1;
`else
    localparam bit ALWAYS_PRE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_op = 8'h00;
    logic [15:0] in_immed = 16'h0000;
    logic        load_addr = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_word;
    logic [15:0] out_addr;
    logic        err;

    inst_encoder #(.RESET_ADDR(16'h0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_immed  (in_immed),
        .load_addr (load_addr),
        .base_addr (base_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [15:0] addr;
    } exp_t;

    typedef struct {
        bit          ld;
        logic [15:0] base;
        logic [7:0]  op;
        logic [15:0] immed;
        bit          bad;
        bit          jmp;
        int          n;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          err_seen = 0;
    logic [15:0] exp_addr = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Scoreboard: compare every word taken by the consumer.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h @%h expected none", out_word, out_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_word", {16'h0, out_word}, {16'h0, e.word});
                check("out_addr", {16'h0, out_addr}, {16'h0, e.addr});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && err) err_seen++;
    end

    task automatic push_exp(input logic [15:0] w);
        exp_t e;
        e.word = w;
        e.addr = exp_addr;
        sb.push_back(e);
        exp_addr = exp_addr + 16'd1;
    endtask

    task automatic send(input logic [7:0] op, input logic [15:0] immed);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        in_op    = op;
        in_immed = immed;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) timeout("send_in_ready");
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) timeout("drain");
    endtask

    task automatic do_load(input logic [15:0] a);
        @(posedge clk);
        #1;
        load_addr = 1'b1;
        base_addr = a;
        #1;
        check("in_ready_during_load", {31'h0, in_ready}, 32'h0);
        @(posedge clk);
        #1;
        load_addr = 1'b0;
        exp_addr  = a;
    endtask

    function automatic vec_t mk(input bit ld, input logic [15:0] base,
                                input logic [7:0] op, input logic [15:0] immed,
                                input bit bad, input bit jmp, input int n,
                                input logic [15:0] w0, input logic [15:0] w1);
        vec_t v;
        v.ld = ld; v.base = base; v.op = op; v.immed = immed;
        v.bad = bad; v.jmp = jmp; v.n = n; v.w0 = w0; v.w1 = w1;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        vec_t v;
        int   err_before;

        // Requests in order; addresses follow from the bench's own counter.
        vecs.push_back(mk(0, 16'h0000, 8'h10, 16'h0005, 0, 0, 1, 16'h1005, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h10, 16'hFFFF, 0, 0, 1, 16'h1FFF, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h10, 16'h1234, 0, 0, 2, 16'hB001, 16'h1234));
        vecs.push_back(mk(1, 16'h0010, 8'h50, 16'h0123, 0, 1, 1, 16'h5123, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h50, 16'h2005, 0, 1, 2, 16'hB002, 16'h5005));
        vecs.push_back(mk(1, 16'h8000, 8'h40, 16'h8123, 0, 1, 2, 16'hB008, 16'h4123));
        vecs.push_back(mk(0, 16'h0000, 8'h00, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h0B, 16'h0000, 0, 0, 1, 16'h000B, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h80, 16'h0FFF, 0, 0, 1, 16'h8FFF, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h70, 16'h0456, 0, 1, 1, 16'h7456, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h80, 16'h1000, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h0C, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'hB0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'hF0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h20, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h10, 16'hF800, 0, 0, 1, 16'h1800, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h10, 16'h07FF, 0, 0, 1, 16'h17FF, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h10, 16'h0800, 0, 0, 2, 16'hB000, 16'h1800));
        vecs.push_back(mk(0, 16'h0000, 8'hA0, 16'h0000, 0, 0, 1, 16'hA000, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h90, 16'h0ABC, 0, 0, 1, 16'h9ABC, 16'h0000));
        vecs.push_back(mk(1, 16'h3FFE, 8'h60, 16'h3123, 0, 1, 1, 16'h6123, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h50, 16'h3123, 0, 1, 1, 16'h5123, 16'h0000));
        vecs.push_back(mk(1, 16'hFFFF, 8'h10, 16'h0001, 0, 0, 1, 16'h1001, 16'h0000));
        vecs.push_back(mk(0, 16'h0000, 8'h10, 16'h0002, 0, 0, 1, 16'h1002, 16'h0000));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_addr", {16'h0, out_addr}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid_run", {31'h0, out_valid}, 32'h0);
        check("rst_out_word", {16'h0, out_word}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);

        // Table-driven requests.
        foreach (vecs[k]) begin
            v = vecs[k];
            if (v.ld) do_load(v.base);
            if (v.jmp && ALWAYS_PRE && v.n == 1) begin
                v.n  = 2;
                v.w1 = v.w0;
                v.w0 = {4'hB, 8'h00, v.immed[15:12]};
            end
            err_before = err_seen;
            if (v.bad) begin
                send(v.op, v.immed);
                repeat (3) @(negedge clk);
                check($sformatf("err_pulse_%0d", k), err_seen - err_before, 1);
                check($sformatf("addr_kept_%0d", k), {16'h0, out_addr}, {16'h0, exp_addr});
            end else begin
                push_exp(v.w0);
                if (v.n == 2) push_exp(v.w1);
                send(v.op, v.immed);
                wait_idle();
                check($sformatf("no_err_%0d", k), err_seen - err_before, 0);
            end
        end

        // Back-pressure during a Pre word, then reset mid-hold.
        out_ready = 1'b0;
        push_exp(16'hB001);
        push_exp(16'h1234);
        send(8'h10, 16'h1234);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            if (!seen) timeout("hold_out_valid");
        end
        @(posedge clk);
        #1;
        load_addr = 1'b1;   // must be ignored while emitting
        base_addr = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_word", {16'h0, out_word}, 32'h0000_B001);
            check("hold_addr", {16'h0, out_addr}, 32'h0000_0001);
            check("hold_in_ready", {31'h0, in_ready}, 32'h0);
            load_addr = 1'b0;
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_out_addr", {16'h0, out_addr}, 32'h0);
        sb.delete();
        exp_addr = 16'h0000;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        err_before = err_seen;
        push_exp(16'h1005);
        send(8'h10, 16'h0005);
        wait_idle();
        check("post_rst_no_err", err_seen - err_before, 0);
        check("post_rst_addr", {16'h0, out_addr}, 32'h0000_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the fetch-stage decoder: converts a symbolic instruction (8-bit state-number op plus a 16-bit immediate) into the 16-bit instruction words the processor fetches.
- Automatically inserts a Pre word when the immediate cannot be reconstructed by the decoder's sign-extension or PC-region rules.
- Sits between the program loader / test stimulus and instruction memory.
- Tracks the memory address of every emitted word.

Parameters:
- RESET_ADDR, 16'h0000, address counter value after reset.

Ports:
- clk  input  1  clock, all state on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  request present.
- in_ready  output  1  encoder accepts a request this cycle.
- in_op  input  8  op in the shared state-number encoding {opcode, subop}.
- in_immed  input  16  full immediate / target.
- load_addr  input  1  load the address counter from base_addr.
- base_addr  input  16  new address counter value.
- out_valid  output  1  out_word/out_addr valid.
- out_ready  input  1  consumer takes the word.
- out_word  output  16  encoded instruction word.
- out_addr  output  16  memory address of out_word.
- err  output  1  one-cycle pulse: an illegal request was accepted and dropped.

Behaviour:
- Reset values: in_ready 1, out_valid 0, out_word 0, out_addr RESET_ADDR, err 0, state IDLE. Reset mid-emission drops the pending word(s) immediately.
- FSM states: IDLE, EMIT_PRE, EMIT_MAIN.
- in_ready = (state==IDLE) && !load_addr.
- load_addr in IDLE: addr <= base_addr. load_addr in any other state is ignored.
- Accept (in_valid && in_ready): latch the op and immed, then classify:
  - Opcode-0 ops (subop 0..B): main = {4'h0, 8'h00, subop}. No Pre.
  - Push: if in_immed[15:11] are all equal, main = {4'h1, immed[11:0]}. Otherwise Pre = {4'hB, 8'h00, immed[15:12]}, then main.
  - Call/Jump/JumpF/JumpT (opcode 4..7): main = {opcode, immed[11:0]}. No Pre iff immed[15]==0 && immed[14:12]==addr[14:12], where addr is the address of the jump word itself. Otherwise Pre first.
  - Get/Put/Pop (8..A): legal only if immed[15:12]==0. Main = {opcode, immed[11:0]}. Never uses Pre.
  - Illegal: subop C..F with opcode 0; any Pre, NOP or other op; Get/Put/Pop with an immediate out of range. Result: err=1 the next cycle, FSM stays IDLE, nothing emitted, addr unchanged.
- Latency: the first word is valid the cycle after accept. out_word and out_addr are registered and held stable while out_valid && !out_ready.
- Each out handshake increments addr (mod 2^16; 16'hFFFF wraps to 0).
- Transitions:
  - EMIT_PRE -> EMIT_MAIN on handshake.
  - EMIT_MAIN -> IDLE on handshake.
- Throughput: at most one request per 2 cycles.
- Pre region check uses the address after the Pre word; it is not needed because Pre is then always used for that request.

Optional Feature:
- Macro: ENC_ALWAYS_PRE_EN.
- Defined: Call/Jump/JumpF/JumpT always emit Pre, giving position-independent, fixed 2-word size. Push rules are unchanged.
- Undefined: Pre is elided as described under Behaviour.

Decomposition:
- Shared package/header (also used by the processor): WORD, Opcode, Immed, PRE field macros; OPAdd..OPPre, OPNOP state-number constants; NOREG.
- One natural sub-module: enc_fit_check.
  - Purely combinational.
  - Inputs: op, immed, addr.
  - Outputs: legal, need_pre, main_word, pre_word.
  - The top level holds the FSM, address counter and output registers.

Test Plan:
- addr 0, Push 16'h0005 -> single word 16'h1005 @0000. Push 16'hFFFF -> 16'h1FFF @0001. err stays 0.
- Push 16'h1234 @0002 -> 16'hB001 @0002, then 16'h1234 @0003. in_ready 0 until the second handshake.
- load_addr 0x0010; Jump 16'h0123 -> 16'h5123 @0010. Jump 16'h2005 -> 16'hB002 @0011, 16'h5005 @0012. With ENC_ALWAYS_PRE_EN, the first jump becomes 16'hB000, 16'h5123.
- load_addr 0x8000; Call 16'h8123 -> 16'hB008 @8000, 16'h4123 @8001. Add (8'h00) -> 16'h0000. Sys (8'h0B) -> 16'h000B.
- Get 16'h1000, op 8'h0C, op 8'hB0 -> err pulses once each, out_valid never rises, out_addr unchanged.
- out_ready held 0 for 3 cycles during a Pre: word/addr stable, in_ready 0. Assert reset mid-hold: out_valid 0 immediately, out_addr = RESET_ADDR, next request encodes cleanly.
